// File: rtl/laser500_pkg.sv
// laser500_pkg: shared arbiter states, grant codes and SDRAM address width
package laser500_pkg;
  localparam int SDRAM_AW = 25;
`ifdef RAM_ARB_ROMWP_EN
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DROP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif
  typedef enum logic [1:0] {GNT_NONE, GNT_DIO, GNT_VID, GNT_CPU} grant_t;
endpackage

// File: rtl/laser500_ram_arb_pick.sv
// laser500_ram_arb_pick: dio > vid > cpu priority, cpu beats vid once the video burst is saturated
module laser500_ram_arb_pick
  import laser500_pkg::*;
(
  input  logic   dio_req,
  input  logic   vid_req,
  input  logic   cpu_req,
  input  logic   vid_sat,
  output grant_t grant
);
  always_comb grant = dio_req ? GNT_DIO :
                      (vid_req && !(cpu_req && vid_sat)) ? GNT_VID :
                      cpu_req ? GNT_CPU : GNT_NONE;
endmodule

// File: rtl/laser500_ram_arbiter.sv
// laser500_ram_arbiter: one-at-a-time SDRAM arbiter for dio/vid/cpu; RAM_ARB_ROMWP_EN drops CPU writes below ROM_TOP
module laser500_ram_arbiter
  import laser500_pkg::*;
#(
  parameter int                   MAX_VID_BURST = 4,
  parameter logic [SDRAM_AW-1:0]  ROM_TOP       = 25'h0010000
) (
  input  logic                F14M,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [SDRAM_AW-1:0] cpu_addr,
  input  logic [7:0]          cpu_din,
  output logic                cpu_ack,
  output logic [7:0]          cpu_dout,
  input  logic                vid_req,
  input  logic [SDRAM_AW-1:0] vid_addr,
  output logic                vid_ack,
  output logic [7:0]          vid_dout,
  input  logic                dio_req,
  input  logic [SDRAM_AW-1:0] dio_addr,
  input  logic [7:0]          dio_din,
  output logic                dio_ack,
  output logic                mem_oe,
  output logic                mem_we,
  output logic [SDRAM_AW-1:0] mem_addr,
  output logic [7:0]          mem_din,
  input  logic [7:0]          mem_dout,
  input  logic                mem_ready,
  output logic                busy
);
  localparam int CW = $clog2(MAX_VID_BURST + 1);
  state_t      state;
  grant_t      grant, win;
  logic        wr, g_wr, vid_sat;
  logic [CW-1:0] vid_cnt;
  assign vid_sat = vid_cnt == CW'(MAX_VID_BURST);
  assign g_wr    = grant == GNT_DIO || (grant == GNT_CPU && cpu_we);
  assign busy    = state != IDLE;
  laser500_ram_arb_pick u_pick (
    .dio_req (dio_req),
    .vid_req (vid_req),
    .cpu_req (cpu_req),
    .vid_sat (vid_sat),
    .grant   (grant)
  );
  always_ff @(posedge F14M) begin
    if (reset) begin
      state    <= IDLE;
      win      <= GNT_NONE;
      wr       <= 1'b0;
      cpu_ack  <= 1'b0;
      vid_ack  <= 1'b0;
      dio_ack  <= 1'b0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      cpu_dout <= '0;
      vid_dout <= '0;
      vid_cnt  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      dio_ack <= 1'b0;
      mem_oe  <= 1'b0;
      mem_we  <= 1'b0;
      if (!cpu_req) vid_cnt <= '0;
      case (state)
        IDLE: if (grant != GNT_NONE) begin
          win      <= grant;
          wr       <= g_wr;
          mem_addr <= grant == GNT_DIO ? dio_addr : grant == GNT_VID ? vid_addr : cpu_addr;
          mem_din  <= grant == GNT_DIO ? dio_din : cpu_din;
          if (grant == GNT_CPU) vid_cnt <= '0;
          else if (grant == GNT_VID && cpu_req && !vid_sat) vid_cnt <= vid_cnt + CW'(1);
`ifdef RAM_ARB_ROMWP_EN
          if (grant == GNT_CPU && cpu_we && cpu_addr < ROM_TOP) state <= DROP;
          else begin
            state  <= ISSUE;
            mem_oe <= !g_wr;
            mem_we <= g_wr;
          end
`else
          state  <= ISSUE;
          mem_oe <= !g_wr;
          mem_we <= g_wr;
`endif
        end
        ISSUE: state <= WAIT;
        WAIT: if (mem_ready) begin
          state   <= IDLE;
          cpu_ack <= win == GNT_CPU;
          vid_ack <= win == GNT_VID;
          dio_ack <= win == GNT_DIO;
          if (!wr && win == GNT_CPU) cpu_dout <= mem_dout;
          if (!wr && win == GNT_VID) vid_dout <= mem_dout;
        end
`ifdef RAM_ARB_ROMWP_EN
        DROP: begin
          state   <= IDLE;
          cpu_ack <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_laser500_ram_arbiter.sv
// tb_laser500_ram_arbiter: directed checks of priority, burst limit, latency, ROM protect and reset abandon
module tb_laser500_ram_arbiter;
  logic        F14M = 1'b0, reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, vid_req = 0, dio_req = 0;
  logic [24:0] cpu_addr = '0, vid_addr = '0, dio_addr = '0;
  logic [7:0]  cpu_din = '0, dio_din = '0;
  logic        cpu_ack, vid_ack, dio_ack, mem_oe, mem_we, mem_ready, busy;
  logic [7:0]  cpu_dout, vid_dout, mem_din, mem_dout;
  logic [24:0] mem_addr;
  int checks = 0, failures = 0;
  int cyc = 0, lat = 1, pend = 0;
  int n_cpu = 0, n_vid = 0, n_dio = 0, n_oe = 0, n_we = 0;
  int st_cyc = 0, ack_cyc = 0, req_cyc = 0;
  logic [24:0] st_addr = '0;
  logic [7:0]  st_din = '0, rd_data = '0;
  int log_q[$];
  laser500_ram_arbiter dut (
    .F14M(F14M), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
    .dio_req(dio_req), .dio_addr(dio_addr), .dio_din(dio_din), .dio_ack(dio_ack),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .busy(busy)
  );
  always #35 F14M = ~F14M;
  initial forever begin
    @(posedge F14M);
    cyc++;
  end
  initial begin
    mem_ready = 0;
    mem_dout = '0;
    forever begin
      @(negedge F14M);
      if (cpu_ack) begin n_cpu++; log_q.push_back(3); ack_cyc = cyc; end
      if (vid_ack) begin n_vid++; log_q.push_back(2); ack_cyc = cyc; end
      if (dio_ack) begin n_dio++; log_q.push_back(1); ack_cyc = cyc; end
      mem_ready = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_ready = 1;
          mem_dout = rd_data ^ st_addr[7:0];
        end
      end
      if (mem_oe) begin n_oe++; st_addr = mem_addr; st_cyc = cyc; end
      if (mem_we) begin n_we++; st_addr = mem_addr; st_din = mem_din; st_cyc = cyc; end
      if (mem_oe || mem_we) pend = lat;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input int n, input bit drop);
    repeat (n) begin
      @(negedge F14M);
      if (drop) begin
        if (cpu_ack) cpu_req = 0;
        if (vid_ack) vid_req = 0;
        if (dio_ack) dio_req = 0;
      end
    end
  endtask
  int b_cpu, b_vid, b_dio, b_oe, b_we, b_log;
  task automatic snap();
    b_cpu = n_cpu; b_vid = n_vid; b_dio = n_dio; b_oe = n_oe; b_we = n_we; b_log = log_q.size();
  endtask
  initial begin
    repeat (3) @(negedge F14M);
    check("rst_busy", busy, 0);
    check("rst_acks", {cpu_ack, vid_ack, dio_ack}, 0);
    check("rst_strobes", {mem_oe, mem_we}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_douts", {cpu_dout, vid_dout, mem_din}, 0);
    reset = 0;
    run(2, 0);
    // single CPU read, ready three cycles after the strobe
    snap();
    lat = 3; rd_data = 8'hA5;
    cpu_req = 1; cpu_we = 0; cpu_addr = 25'h0014000; req_cyc = cyc;
    run(15, 1);
    check("rd_cpu_dout", cpu_dout, 8'hA5);
    check("rd_cpu_ack", n_cpu - b_cpu, 1);
    check("rd_other_acks", (n_vid - b_vid) + (n_dio - b_dio), 0);
    check("rd_oe_once", n_oe - b_oe, 1);
    check("rd_no_we", n_we - b_we, 0);
    check("rd_addr", st_addr, 25'h0014000);
    check("rd_req_to_strobe", st_cyc - req_cyc, 1);
    check("rd_strobe_to_ack", ack_cyc - st_cyc, 4);
    check("rd_idle", busy, 0);
    // minimum latency
    lat = 1; rd_data = 8'h00;
    cpu_req = 1; cpu_addr = 25'h0014007; req_cyc = cyc;
    run(10, 1);
    check("min_req_to_strobe", st_cyc - req_cyc, 1);
    check("min_strobe_to_ack", ack_cyc - st_cyc, 2);
    check("min_cpu_dout", cpu_dout, 8'h07);
    // all three at once
    snap();
    dio_req = 1; dio_addr = 25'h0020000; dio_din = 8'h3C;
    vid_req = 1; vid_addr = 25'h0001042;
    cpu_req = 1; cpu_we = 0; cpu_addr = 25'h0002010;
    run(30, 1);
    check("all_n_acks", log_q.size() - b_log, 3);
    check("all_first_dio", log_q.size() > b_log ? log_q[b_log] : 0, 1);
    check("all_second_vid", log_q.size() > b_log + 1 ? log_q[b_log+1] : 0, 2);
    check("all_third_cpu", log_q.size() > b_log + 2 ? log_q[b_log+2] : 0, 3);
    check("all_each_once", {8'(n_dio - b_dio), 8'(n_vid - b_vid), 8'(n_cpu - b_cpu)}, 24'h010101);
    check("all_dio_we_din", {8'(n_we - b_we), st_din}, 16'h013C);
    check("all_vid_dout", vid_dout, 8'h42);
    check("all_cpu_dout", cpu_dout, 8'h10);
    // continuous vid + cpu: four video grants then one cpu grant
    snap();
    vid_req = 1; cpu_req = 1; cpu_we = 0;
    for (int i = 0; i < 200 && log_q.size() < b_log + 10; i++) run(1, 0);
    for (int i = 0; i < 10; i++)
      check($sformatf("burst_%0d", i), log_q.size() > b_log + i ? log_q[b_log+i] : 0, (i % 5 == 4) ? 3 : 2);
    vid_req = 0; cpu_req = 0;
    run(10, 0);
    check("burst_idle", busy, 0);
    // CPU write into ROM area
    snap();
    cpu_req = 1; cpu_we = 1; cpu_addr = 25'h0000100; cpu_din = 8'h55;
    run(10, 1);
    check("rom_cpu_ack", n_cpu - b_cpu, 1);
    check("rom_dout_kept", cpu_dout, 8'h10);
`ifdef RAM_ARB_ROMWP_EN
    check("rom_no_we", n_we - b_we, 0);
`else
    check("rom_we", n_we - b_we, 1);
    check("rom_we_din", st_din, 8'h55);
`endif
    snap();
    dio_req = 1; dio_addr = 25'h0000100; dio_din = 8'h66;
    run(10, 1);
    check("rom_dio_we", {8'(n_we - b_we), 8'(n_dio - b_dio), st_din}, 24'h010166);
    snap();
    cpu_req = 1; cpu_we = 1; cpu_addr = 25'h0020000; cpu_din = 8'h77;
    run(10, 1);
    check("ram_cpu_we", {8'(n_we - b_we), 8'(n_cpu - b_cpu), st_din}, 24'h010177);
    // reset while waiting for the SDRAM, stray ready afterwards
    snap();
    lat = 5; rd_data = 8'hEE;
    cpu_req = 1; cpu_we = 0; cpu_addr = 25'h0014033;
    run(3, 0);
    check("abn_busy_in_wait", busy, 1);
    reset = 1;
    run(1, 0);
    reset = 0; cpu_req = 0;
    run(8, 0);
    check("abn_no_ack", (n_cpu - b_cpu) + (n_vid - b_vid) + (n_dio - b_dio), 0);
    check("abn_busy", busy, 0);
    check("abn_mem_addr", mem_addr, 0);
    check("abn_douts", {cpu_dout, vid_dout, mem_din}, 0);
    check("abn_outs", {cpu_ack, vid_ack, dio_ack, mem_oe, mem_we}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
